// File: rtl/sfx_arbiter.sv
// sfx_arbiter: shares the one-bit speaker among three game sound events.
// Optional build macro SFX_PREEMPT_EN lets a higher-priority event cut a tone short.
module sfx_arbiter #(
    parameter int unsigned HALF_P0    = 28409,
    parameter int unsigned HALF_P1    = 18939,
    parameter int unsigned HALF_P2    = 14204,
    parameter int unsigned DUR_FRAMES = 8,
    parameter int unsigned GAP_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_frame_end,
    input  logic [2:0] i_req,
    output logic [2:0] o_grant,
    output logic [2:0] o_pending,
    output logic       o_busy,
    output logic       o_sound
);

    // Terminal tone count per event; a half-period of 0 or 1 gives a
    // terminal of 0, so the tone toggles every cycle.
    localparam logic [15:0] LP_TOP0 = (HALF_P0 <= 1) ? 16'd0 : 16'(HALF_P0 - 1);
    localparam logic [15:0] LP_TOP1 = (HALF_P1 <= 1) ? 16'd0 : 16'(HALF_P1 - 1);
    localparam logic [15:0] LP_TOP2 = (HALF_P2 <= 1) ? 16'd0 : 16'(HALF_P2 - 1);
    localparam logic [5:0]  LP_DUR  = 6'(DUR_FRAMES);
    localparam logic [5:0]  LP_GAP  = 6'(GAP_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_req_q;
    logic [2:0]  r_pending;
    logic [2:0]  r_grant;
    logic        r_sound;
    logic [5:0]  r_frame_cnt;
    logic [15:0] r_tone_cnt;

    logic [2:0]  w_rise;
    logic [2:0]  w_pick;
    logic [2:0]  w_take;
    logic [15:0] w_tone_top;
    logic        w_tone_hit;
    logic        w_preempt;
    logic        w_frame_last;

    // Edge detect, lowest-pending pick, tone terminal and take decode.
    always_comb begin
        w_rise       = i_req & ~r_req_q;
        w_pick       = r_pending & (~r_pending + 3'd1);
        w_tone_top   = LP_TOP2;
        case (1'b1)
            r_grant[0]: w_tone_top = LP_TOP0;
            r_grant[1]: w_tone_top = LP_TOP1;
            default:    w_tone_top = LP_TOP2;
        endcase
        w_tone_hit   = (r_tone_cnt == w_tone_top);
        w_frame_last = i_frame_end && (r_frame_cnt == 6'd1);
`ifdef SFX_PREEMPT_EN
        // Bits below the one-hot grant are exactly the higher-priority ones.
        w_preempt = (r_state == S_PLAY) && (|(r_pending & (r_grant - 3'd1)));
`else
        w_preempt = 1'b0;
`endif
        w_take = ((r_state == S_IDLE) || w_preempt) ? w_pick : 3'b000;
    end

    // Copy of req follows the line even in reset, so a level held through
    // reset is not mistaken for a fresh edge afterwards.
    always_ff @(posedge i_clk) begin
        r_req_q <= i_req;
    end

    // Queue: clear the bit granted this cycle, a new edge on it wins.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pending <= 3'b000;
        end else begin
            r_pending <= (r_pending & ~w_take) | w_rise;
        end
    end

    // Grant / tone / gap sequencer with registered grant and sound.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= 3'b000;
            r_sound     <= 1'b0;
            r_frame_cnt <= 6'd0;
            r_tone_cnt  <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|r_pending) begin
                        r_grant     <= w_pick;
                        r_frame_cnt <= LP_DUR;
                        r_tone_cnt  <= 16'd0;
                        r_sound     <= 1'b0;
                        r_state     <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (w_preempt) begin
                        r_grant     <= w_pick;
                        r_frame_cnt <= LP_DUR;
                        r_tone_cnt  <= 16'd0;
                        r_sound     <= 1'b0;
                    end else if (w_frame_last) begin
                        r_grant    <= 3'b000;
                        r_sound    <= 1'b0;
                        r_tone_cnt <= 16'd0;
                        if (LP_GAP == 6'd0) begin
                            r_frame_cnt <= 6'd0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_frame_cnt <= LP_GAP;
                            r_state     <= S_GAP;
                        end
                    end else begin
                        if (w_tone_hit) begin
                            r_tone_cnt <= 16'd0;
                            r_sound    <= ~r_sound;
                        end else begin
                            r_tone_cnt <= r_tone_cnt + 16'd1;
                        end
                        if (i_frame_end) begin
                            r_frame_cnt <= r_frame_cnt - 6'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_sound <= 1'b0;
                    if (w_frame_last) begin
                        r_frame_cnt <= 6'd0;
                        r_state     <= S_IDLE;
                    end else if (i_frame_end) begin
                        r_frame_cnt <= r_frame_cnt - 6'd1;
                    end
                end
                default: begin
                    r_grant <= 3'b000;
                    r_sound <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant   = r_grant;
    assign o_pending = r_pending;
    assign o_busy    = (r_state != S_IDLE);
    assign o_sound   = r_sound;

endmodule
